// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath.
// Carries IR/mem_ack into the sequencer and all control strobes out.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        mem_ack;
  logic        Pout;
  logic        MARen;
  logic        IncPC;
  logic        Read;
  logic        MDRen;
  logic        MDROut;
  logic        IRen;
  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;
  logic        BAout;
  logic        Yen;
  logic        Cout;
  logic        Zen;
  logic        ZLOout;
  logic        Write;
  logic [4:0]  alu_control;
  logic        Run;

  modport master (
    input  IR, mem_ack,
    output Pout, MARen, IncPC, Read, MDRen,
    output MDROut, IRen, Gra, Grb, Grc,
    output Rin, Rout, BAout, Yen, Cout,
    output Zen, ZLOout, Write, alu_control, Run
  );

  modport slave (
    output IR, mem_ack,
    input  Pout, MARen, IncPC, Read, MDRen,
    input  MDROut, IRen, Gra, Grb, Grc,
    input  Rin, Rout, BAout, Yen, Cout,
    input  Zen, ZLOout, Write, alu_control, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// Microsequencer: IDLE, T0..T7, HALT; Moore registered controls.
// Ports: clk, clr (sync active-low), bus (master: IR/mem_ack in, controls out).
module control_sequencer (
  input logic                 clk,
  input logic                 clr,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00100;
  localparam logic [4:0] ALU_SHR  = 5'b00101;
  localparam logic [4:0] ALU_SHL  = 5'b00110;

  typedef struct packed {
    logic       pout;
    logic       maren;
    logic       incpc;
    logic       read;
    logic       mdren;
    logic       mdrout;
    logic       iren;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       baout;
    logic       yen;
    logic       cout;
    logic       zen;
    logic       zloout;
    logic       write;
    logic [4:0] alu;
    logic       run;
  } ctl_t;

  state_t     state_q;
  state_t     state_d;
  logic [4:0] op_q;
  logic [4:0] op_d;
  ctl_t       ctl_q;

  function automatic logic is_r(logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND,
                      OP_OR, OP_SHR, OP_SHL};
  endfunction

  function automatic logic is_i(logic [4:0] op);
    return op inside {OP_ADDI, OP_ANDI, OP_ORI};
  endfunction

  // ldi, ld and st all form an address/value as rB (or 0) + C.
  function automatic logic is_m(logic [4:0] op);
    return op inside {OP_LDI, OP_LD, OP_ST};
  endfunction

  function automatic logic [4:0] alu_of(logic [4:0] op);
    logic [4:0] a;
    a = ALU_NONE;
    unique case (1'b1)
      op inside {OP_ADD, OP_ADDI}: a = ALU_ADD;
      is_m(op):                    a = ALU_ADD;
      op == OP_SUB:                a = ALU_SUB;
      op inside {OP_AND, OP_ANDI}: a = ALU_AND;
      op inside {OP_OR, OP_ORI}:   a = ALU_OR;
      op == OP_SHR:                a = ALU_SHR;
      op == OP_SHL:                a = ALU_SHL;
      default:                     a = ALU_NONE;
    endcase
    return a;
  endfunction

  function automatic ctl_t decode(state_t s,
                                  logic [4:0] op);
    ctl_t c;
    c = '0;
    c.run = (s != S_IDLE) && (s != S_HALT);
    case (s)
      S_T0: begin
        c.pout  = 1'b1;
        c.maren = 1'b1;
        c.incpc = 1'b1;
      end
      S_T1: begin
        c.read  = 1'b1;
        c.mdren = 1'b1;
      end
      S_T2: begin
        c.mdrout = 1'b1;
        c.iren   = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          is_r(op) || is_i(op): begin
            c.grb  = 1'b1;
            c.rout = 1'b1;
            c.yen  = 1'b1;
          end
          is_m(op): begin
            c.grb   = 1'b1;
            c.baout = 1'b1;
            c.yen   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        c.zen = 1'b1;
        c.alu = alu_of(op);
        if (is_r(op)) begin
          c.grc  = 1'b1;
          c.rout = 1'b1;
        end else begin
          c.cout = 1'b1;
        end
      end
      S_T5: begin
        c.zloout = 1'b1;
        c.alu    = alu_of(op);
        if (op == OP_LD || op == OP_ST) begin
          c.maren = 1'b1;
        end else begin
          c.gra = 1'b1;
          c.rin = 1'b1;
        end
      end
      S_T6: begin
        c.mdren = 1'b1;
        if (op == OP_ST) begin
          c.gra  = 1'b1;
          c.rout = 1'b1;
        end else begin
          c.read = 1'b1;
        end
      end
      S_T7: begin
        if (op == OP_ST) begin
          c.write = 1'b1;
        end else begin
          c.mdrout = 1'b1;
          c.gra    = 1'b1;
          c.rin    = 1'b1;
        end
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (bus.mem_ack) state_d = S_T2;
      S_T2: begin
        state_d = S_T3;
        op_d    = bus.IR[31:27];
      end
      S_T3: begin
        if (is_r(op_q) || is_i(op_q) || is_m(op_q))
          state_d = S_T4;
        else if (op_q == OP_HALT)
          state_d = S_HALT;
        else
          state_d = S_T0;
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (op_q == OP_LD || op_q == OP_ST)
          state_d = S_T6;
        else
          state_d = S_T0;
      end
      // st moves on unconditionally; ld waits for the read.
      S_T6: begin
        if (op_q == OP_ST || bus.mem_ack)
          state_d = S_T7;
      end
      // ld finishes unconditionally; st waits for the write.
      S_T7: begin
        if (op_q == OP_LD || bus.mem_ack)
          state_d = S_T0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Controls are decoded from the next state so they are
  // registered yet line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctl_q   <= decode(state_d, op_d);
    end
  end

  logic unused_ir;
  assign unused_ir = ^bus.IR[26:0];

  assign bus.Pout        = ctl_q.pout;
  assign bus.MARen       = ctl_q.maren;
  assign bus.IncPC       = ctl_q.incpc;
  assign bus.Read        = ctl_q.read;
  assign bus.MDRen       = ctl_q.mdren;
  assign bus.MDROut      = ctl_q.mdrout;
  assign bus.IRen        = ctl_q.iren;
  assign bus.Gra         = ctl_q.gra;
  assign bus.Grb         = ctl_q.grb;
  assign bus.Grc         = ctl_q.grc;
  assign bus.Rin         = ctl_q.rin;
  assign bus.Rout        = ctl_q.rout;
  assign bus.BAout       = ctl_q.baout;
  assign bus.Yen         = ctl_q.yen;
  assign bus.Cout        = ctl_q.cout;
  assign bus.Zen         = ctl_q.zen;
  assign bus.ZLOout      = ctl_q.zloout;
  assign bus.Write       = ctl_q.write;
  assign bus.alu_control = ctl_q.alu;
  assign bus.Run         = ctl_q.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer.
// Each step: drive clr/mem_ack, clock once, compare all outputs.
module tb_control_sequencer;

  logic clk;
  logic clr;
  int   n_vec;
  int   n_bad;
  bit   chk_en;

  control_sequencer_if b ();

  control_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [23:0] POUT = 24'd1 << 23;
  localparam logic [23:0] MAR  = 24'd1 << 22;
  localparam logic [23:0] INC  = 24'd1 << 21;
  localparam logic [23:0] RD   = 24'd1 << 20;
  localparam logic [23:0] MDRE = 24'd1 << 19;
  localparam logic [23:0] MDO  = 24'd1 << 18;
  localparam logic [23:0] IRE  = 24'd1 << 17;
  localparam logic [23:0] GRA  = 24'd1 << 16;
  localparam logic [23:0] GRB  = 24'd1 << 15;
  localparam logic [23:0] GRC  = 24'd1 << 14;
  localparam logic [23:0] RIN  = 24'd1 << 13;
  localparam logic [23:0] ROUT = 24'd1 << 12;
  localparam logic [23:0] BA   = 24'd1 << 11;
  localparam logic [23:0] YEN  = 24'd1 << 10;
  localparam logic [23:0] COUT = 24'd1 << 9;
  localparam logic [23:0] ZEN  = 24'd1 << 8;
  localparam logic [23:0] ZLO  = 24'd1 << 7;
  localparam logic [23:0] WR   = 24'd1 << 6;
  localparam logic [23:0] RUN  = 24'd1;

  localparam logic [23:0] F0 = POUT | MAR | INC | RUN;
  localparam logic [23:0] F1 = RD | MDRE | RUN;
  localparam logic [23:0] F2 = MDO | IRE | RUN;
  localparam logic [23:0] A1 = 24'd1 << 1;
  localparam logic [23:0] A3 = 24'd3 << 1;
  localparam logic [23:0] T3M = GRB | BA | YEN | RUN;
  localparam logic [23:0] T4M = COUT | ZEN | A1 | RUN;

  function automatic logic [23:0] obs();
    return {b.Pout, b.MARen, b.IncPC, b.Read,
            b.MDRen, b.MDROut, b.IRen, b.Gra,
            b.Grb, b.Grc, b.Rin, b.Rout,
            b.BAout, b.Yen, b.Cout, b.Zen,
            b.ZLOout, b.Write, b.alu_control,
            b.Run};
  endfunction

  function automatic logic [25:0] v(bit c, bit a,
                                    logic [23:0] x);
    return {c, a, x};
  endfunction

  // Single bus driver, checked between edges every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if ($countones({b.Pout, b.MDROut, b.Rout,
                      b.ZLOout, b.Cout}) > 1) begin
        n_bad++;
        $display("FAIL bus_excl: got %h want <=1 driver",
                 obs());
      end
    end
  end

  task automatic test_reset();
    logic [25:0] t[$];
    b.IR = 32'h0;
    t = {v(0, 0, 24'h0), v(0, 1, 24'h0),
         v(1, 0, F0)};
    foreach (t[i]) begin
      clr = t[i][25];
      b.mem_ack = t[i][24];
      @(posedge clk); #1;
      chk_en = 1'b1;
      n_vec++;
      if (obs() !== t[i][23:0]) begin
        n_bad++;
        $display("FAIL reset step %0d: got %h want %h",
                 i, obs(), t[i][23:0]);
      end
    end
  endtask

  task automatic test_andi();
    logic [25:0] t[$];
    b.IR = 32'h6888_0005;
    t = {v(1, 1, F1), v(1, 1, F2),
         v(1, 0, GRB | ROUT | YEN | RUN),
         v(1, 0, COUT | ZEN | A3 | RUN),
         v(1, 0, ZLO | GRA | RIN | A3 | RUN),
         v(1, 0, F0)};
    foreach (t[i]) begin
      clr = t[i][25];
      b.mem_ack = t[i][24];
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== t[i][23:0]) begin
        n_bad++;
        $display("FAIL andi step %0d: got %h want %h",
                 i, obs(), t[i][23:0]);
      end
      if (i == 2) b.IR = 32'hD800_0000;
    end
  endtask

  task automatic test_rtype();
    logic [25:0] t[$];
    logic [23:0] a;
    for (int k = 0; k < 6; k++) begin
      b.IR = {5'(k + 3), 27'h0};
      a = 24'(k + 1) << 1;
      t = {v(1, 0, F1), v(1, 0, F1), v(1, 1, F2),
           v(1, 0, GRB | ROUT | YEN | RUN),
           v(1, 0, GRC | ROUT | ZEN | a | RUN),
           v(1, 0, ZLO | GRA | RIN | a | RUN),
           v(1, 0, F0)};
      foreach (t[i]) begin
        clr = t[i][25];
        b.mem_ack = t[i][24];
        @(posedge clk); #1;
        n_vec++;
        if (obs() !== t[i][23:0]) begin
          n_bad++;
          $display("FAIL rtype op%0d step %0d: got %h want %h",
                   k + 3, i, obs(), t[i][23:0]);
        end
      end
    end
  endtask

  task automatic test_ldi();
    logic [25:0] t[$];
    b.IR = 32'h0800_0000;
    t = {v(1, 1, F1), v(1, 1, F2), v(1, 1, T3M),
         v(1, 1, T4M),
         v(1, 1, ZLO | GRA | RIN | A1 | RUN),
         v(1, 0, F0)};
    foreach (t[i]) begin
      clr = t[i][25];
      b.mem_ack = t[i][24];
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== t[i][23:0]) begin
        n_bad++;
        $display("FAIL ldi step %0d: got %h want %h",
                 i, obs(), t[i][23:0]);
      end
    end
  endtask

  task automatic test_ld();
    logic [25:0] t[$];
    b.IR = 32'h0000_0000;
    t = {v(1, 1, F1), v(1, 1, F2), v(1, 0, T3M),
         v(1, 0, T4M),
         v(1, 0, ZLO | MAR | A1 | RUN),
         v(1, 1, F1), v(1, 0, F1), v(1, 0, F1),
         v(1, 0, F1),
         v(1, 1, MDO | GRA | RIN | RUN),
         v(1, 0, F0)};
    foreach (t[i]) begin
      clr = t[i][25];
      b.mem_ack = t[i][24];
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== t[i][23:0]) begin
        n_bad++;
        $display("FAIL ld step %0d: got %h want %h",
                 i, obs(), t[i][23:0]);
      end
    end
  endtask

  task automatic test_st();
    logic [25:0] t[$];
    b.IR = 32'h1000_0000;
    t = {v(1, 1, F1), v(1, 1, F2), v(1, 0, T3M),
         v(1, 0, T4M),
         v(1, 0, ZLO | MAR | A1 | RUN),
         v(1, 1, GRA | ROUT | MDRE | RUN),
         v(1, 1, WR | RUN), v(1, 0, WR | RUN),
         v(1, 0, WR | RUN), v(1, 1, F0)};
    foreach (t[i]) begin
      clr = t[i][25];
      b.mem_ack = t[i][24];
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== t[i][23:0]) begin
        n_bad++;
        $display("FAIL st step %0d: got %h want %h",
                 i, obs(), t[i][23:0]);
      end
    end
  endtask

  task automatic test_nop_unmapped();
    logic [25:0] t[$];
    logic [31:0] irs [2];
    irs[0] = 32'hF800_0000;
    irs[1] = 32'hD000_0000;
    for (int k = 0; k < 2; k++) begin
      b.IR = irs[k];
      t = {v(1, 1, F1), v(1, 1, F2),
           v(1, 1, RUN), v(1, 0, F0)};
      foreach (t[i]) begin
        clr = t[i][25];
        b.mem_ack = t[i][24];
        @(posedge clk); #1;
        n_vec++;
        if (obs() !== t[i][23:0]) begin
          n_bad++;
          $display("FAIL nop ir=%h step %0d: got %h want %h",
                   irs[k], i, obs(), t[i][23:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [25:0] t[$];
    b.IR = 32'h1800_0000;
    t = {v(1, 0, F1), v(1, 0, F1),
         v(0, 0, 24'h0), v(1, 0, F0), v(1, 1, F1),
         v(1, 1, F2), v(1, 0, GRB | ROUT | YEN | RUN),
         v(0, 0, 24'h0), v(1, 0, F0)};
    foreach (t[i]) begin
      clr = t[i][25];
      b.mem_ack = t[i][24];
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== t[i][23:0]) begin
        n_bad++;
        $display("FAIL rst_wait step %0d: got %h want %h",
                 i, obs(), t[i][23:0]);
      end
    end
  endtask

  task automatic test_halt();
    logic [25:0] t[$];
    b.IR = 32'hD800_0000;
    t = {v(1, 1, F1), v(1, 1, F2), v(1, 0, RUN),
         v(1, 0, 24'h0)};
    for (int k = 0; k < 10; k++)
      t.push_back(v(1, 1'(k & 1), 24'h0));
    t.push_back(v(0, 0, 24'h0));
    t.push_back(v(1, 0, F0));
    t.push_back(v(1, 0, F1));
    foreach (t[i]) begin
      clr = t[i][25];
      b.mem_ack = t[i][24];
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== t[i][23:0]) begin
        n_bad++;
        $display("FAIL halt step %0d: got %h want %h",
                 i, obs(), t[i][23:0]);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    chk_en = 1'b0;
    clr = 1'b0;
    b.mem_ack = 1'b0;
    b.IR = 32'h0;
    test_reset();
    test_andi();
    test_rtype();
    test_ldi();
    test_ld();
    test_st();
    test_nop_unmapped();
    test_reset_mid_wait();
    test_halt();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
